// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a small TX FIFO.
//   0x0 DATA   (write-only) : push mem_wdata[7:0] when mem_wmask[0] is set
//   0x4 STATUS (read-only)  : {28'b0, OVF, busy, empty, full}
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    REG_DATA   = 2'd0;
  localparam logic [1:0]    REG_STATUS = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_e;

  // Even parity: XOR of all data bits, so the frame carries an even count of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_e            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [7:0]        fifo_head_s;
  logic              baud_done_s;
  logic              pop_s;
  logic              push_req_s;
  logic              push_s;
  logic              ovf_evt_s;
  logic              status_rd_s;
  logic              unused_s;

  // Bits of the bus that carry no meaning for this block.
  assign unused_s = ^{mem_wdata[31:8], mem_addr[1:0], mem_wmask[3:1]};

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head_s  = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign baud_done_s  = (baud_q == BAUD_MAX);

  assign push_req_s  = sel & mem_wmask[0] & (mem_addr[3:2] == REG_DATA);
  assign push_s      = push_req_s & (~fifo_full_s | pop_s);
  assign ovf_evt_s   = push_req_s & fifo_full_s & ~pop_s;
  assign status_rd_s = sel & mem_rstrb & (mem_addr[3:2] == REG_STATUS);

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign mem_rdata = rdata_q;

  // Serializer next state, counters, pop request and the next tx level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        bit_d  = 3'd0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_head_s;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(fifo_head_s);
`endif
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_done_s) begin
          baud_d = {BW{1'b0}};
          if (!fifo_empty_s) begin
            // Chain straight into the next start bit without an idle cycle.
            pop_s   = 1'b1;
            shift_d = fifo_head_s;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(fifo_head_s);
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, overflow flag, busy and register read-back.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A drop in the same cycle as the clearing read wins, so no overflow is lost.
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (status_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (sel && mem_rstrb) begin
      if (mem_addr[3:2] == REG_STATUS) begin
        rdata_d = {28'd0, ovf_q, busy_q, fifo_empty_s, fifo_full_s};
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      rdata_d = rdata_q;
    end

    busy_d = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      baud_q   <= {BW{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'd0;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents are cleared by reset so no stale byte survives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 8'd0;
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata[7:0];
    end else begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= fifo_mem_q[wr_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Frame expectations follow UART_TX_PARITY_EN when it is defined.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad   = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; mem_addr = a; mem_wdata = d; mem_wmask = m;
    tick();
    sel = 1'b0; mem_wmask = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a);
    sel = 1'b1; mem_addr = a; mem_rstrb = 1'b1;
    tick();
    sel = 1'b0; mem_rstrb = 1'b0;
  endtask

  // Called on the first cycle of the start bit; returns on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input logic par, input string tag);
    logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, par, b, 1'b0};
`else
    fr = {1'b1, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < CPB; c++) begin
        chk(tag, {31'd0, tx}, {31'd0, fr[k]});
        if (c == 0) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
      end
    end
  endtask

  initial begin
    int lows;
    resetn = 1'b0; sel = 1'b0; mem_addr = 4'h0; mem_wdata = 32'd0;
    mem_wmask = 4'h0; mem_rstrb = 1'b0;
    #22;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single byte, written on the first edge after reset release.
    wr(4'h0, 32'h0000_0055, 4'h1);
    chk("pre_start_tx", {31'd0, tx}, 32'd1);
    chk("pre_start_busy", {31'd0, busy}, 32'd1);
    tick();
    check_frame(8'h55, 1'b0, "frame_55");
    chk("after_55_tx", {31'd0, tx}, 32'd1);
    chk("after_55_busy", {31'd0, busy}, 32'd0);
    rd(4'h4);
    chk("status_idle", mem_rdata, 32'h0000_0002);

    // Parity cases: 0xA3 has four ones, 0x07 has three.
    wr(4'h0, 32'h0000_00A3, 4'h1);
    tick();
    check_frame(8'hA3, 1'b0, "frame_a3");
    wr(4'h0, 32'h0000_0007, 4'h1);
    tick();
    check_frame(8'h07, 1'b1, "frame_07");
    chk("after_07_busy", {31'd0, busy}, 32'd0);

    // Six back-to-back writes: one popped at once, four fill the FIFO, one dropped.
    for (int i = 0; i < 6; i++) begin
      sel = 1'b1; mem_addr = 4'h0; mem_wmask = 4'h1; mem_wdata = 32'h11 + 32'(i);
      tick();
    end
    sel = 1'b0; mem_wmask = 4'h0;
    rd(4'h4);
    chk("status_ovf", mem_rdata, 32'h0000_000D);
    rd(4'h4);
    chk("status_ovf_cleared", mem_rdata, 32'h0000_0005);
    chk("frame_11_bit0", {31'd0, tx}, 32'd1);
    repeat (FRAME_CYC - 6) tick();
    check_frame(8'h12, 1'b0, "frame_12");
    check_frame(8'h13, 1'b1, "frame_13");
    check_frame(8'h14, 1'b0, "frame_14");
    check_frame(8'h15, 1'b1, "frame_15");
    chk("dropped_tx", {31'd0, tx}, 32'd1);
    chk("dropped_busy", {31'd0, busy}, 32'd0);
    rd(4'h4);
    chk("status_after_burst", mem_rdata, 32'h0000_0002);

    // Fill the FIFO, then write in exactly the cycle the serializer pops.
    for (int i = 0; i < 5; i++) begin
      sel = 1'b1; mem_addr = 4'h0; mem_wmask = 4'h1; mem_wdata = 32'h21 + 32'(i);
      tick();
    end
    sel = 1'b0; mem_wmask = 4'h0;
    rd(4'h4);
    chk("status_full", mem_rdata, 32'h0000_0005);
    repeat (FRAME_CYC - 5) tick();
    wr(4'h0, 32'h0000_0026, 4'h1);
    check_frame(8'h22, 1'b0, "frame_22");
    check_frame(8'h23, 1'b1, "frame_23");
    check_frame(8'h24, 1'b0, "frame_24");
    check_frame(8'h25, 1'b1, "frame_25");
    check_frame(8'h26, 1'b1, "frame_26");
    chk("popwr_busy", {31'd0, busy}, 32'd0);
    rd(4'h4);
    chk("status_popwr_no_ovf", mem_rdata, 32'h0000_0002);

    // Reset during data bit 3 of 0x55 with another byte queued.
    wr(4'h0, 32'h0000_0055, 4'h1);
    wr(4'h0, 32'h0000_0066, 4'h1);
    rd(4'h4);
    chk("status_queued", mem_rdata, 32'h0000_0004);
    repeat (16) tick();
    chk("bit3_low", {31'd0, tx}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", mem_rdata, 32'd0);
    tick();
    resetn = 1'b1;
    rd(4'h4);
    chk("status_after_rst", mem_rdata, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    chk("no_residual_frame", 32'(lows), 32'd0);
    chk("no_residual_busy", {31'd0, busy}, 32'd0);

    // Unmapped read, write to STATUS, DATA write without byte 0 enabled.
    rd(4'h8);
    chk("read_unmapped", mem_rdata, 32'd0);
    wr(4'h4, 32'h0000_00FF, 4'hF);
    wr(4'h0, 32'h0000_005A, 4'hE);
    repeat (3) tick();
    chk("ignored_wr_tx", {31'd0, tx}, 32'd1);
    chk("ignored_wr_busy", {31'd0, busy}, 32'd0);
    rd(4'h4);
    chk("status_unchanged", mem_rdata, 32'h0000_0002);
    mem_addr = 4'h8; mem_rstrb = 1'b1;
    repeat (3) tick();
    mem_rstrb = 1'b0;
    chk("rdata_hold", mem_rdata, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
